cpu_program_loader: RTL and testbench
=====================================

Name: cpu_program_loader

Overview:
- Host-side initiator for the CPU load port (cpu_input / load_address / load / is_instruction).
- Takes a framed byte stream on a valid/ready interface and sequences one load strobe per data byte into consecutive CPU memory addresses.
- Holds the CPU in reset while it loads, and releases it on request.
- Sits between the external byte source (pin deserializer or test ROM) and the CPU instance in the top-level wrapper.

Parameters:
- ADDR_W, 5, CPU load-address width; memory depth is 2**ADDR_W.
- DATA_W, 8, byte width of the stream and of cpu_input.
- LOAD_HOLD, 1, number of cycles load stays high per byte; legal range 1..15.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- in_data  input  DATA_W  stream byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts a byte; a transfer occurs when in_valid and in_ready are both high on a clk edge.
- cpu_input  output  DATA_W  byte presented to the CPU load port.
- load_address  output  ADDR_W  target address.
- load  output  1  write strobe to the CPU.
- is_instruction  output  1  1 = instruction memory, 0 = data memory.
- cpu_reset  output  1  active-high reset for the CPU.
- busy  output  1  a frame is in progress.
- err  output  1  sticky bad-length flag.

Behaviour:
- Reset values: cpu_reset=1, load=0, load_address=0, cpu_input=0, is_instruction=0, in_ready=0, busy=0, err=0. All outputs are registered.
- Asserting reset mid-frame aborts the frame at once. load drops to 0 and no partial strobe follows.
- Frame format:
  - Header byte: bit7 = is_instruction, bit6 = GO, bit5 ignored, bits4:0 = start address.
  - Length byte: bits5:0 = N, 0..32; bits7:6 ignored.
  - Then N data bytes.
- States: HDR, LEN, DATA, STROBE, RUN.
- HDR:
  - in_ready=1. On transfer, latch is_instruction, GO and the address.
  - cpu_reset is set to 1 and busy to 1. Go to LEN.
- LEN:
  - in_ready=1. On transfer:
    - N=0: go to RUN if GO, otherwise HDR; busy returns to 0.
    - N>32: set err=1 and go to HDR with busy=0. The following bytes are parsed as a new header.
    - Otherwise: load the counter with N and go to DATA.
- DATA:
  - in_ready=1. On a transfer at edge T, register cpu_input=in_data, load=1, in_ready=0, and go to STROBE.
- STROBE:
  - load stays high for exactly LOAD_HOLD cycles, from edge T through T+LOAD_HOLD; address and data are held stable.
  - At the last hold cycle: load=0, address increments mod 2**ADDR_W (31 wraps to 0), counter decrements.
  - Counter now 0: go to RUN if GO, otherwise HDR; busy=0. Otherwise return to DATA.
- Throughput: one byte per LOAD_HOLD+1 cycles.
- cpu_input and load_address keep their last values after the frame ends.
- RUN:
  - cpu_reset=0 on the cycle after entry; in_ready=1; busy=0.
  - A transfer in RUN is a new header: the HDR actions apply and cpu_reset returns to 1 on the next edge, so reloading is always allowed.
- Address wrap within a frame (start + N > 32) is legal. It is not an error.
- err clears only on reset.
- in_valid with in_ready low is ignored. Source bytes are never dropped, because the source must hold them until accepted.

Decomposition:
- Shared package (cpu_pkg): state enum, ADDR_W/DATA_W defaults, header bit positions (HDR_INSTR_BIT=7, HDR_GO_BIT=6), MAX_LEN=32.
- Sub-module: loader_hold_counter, a down-counter that times the LOAD_HOLD strobe.
- Everything else stays in a single FSM module.

Test Plan:
- Reset, then stream 0x83, 0x02, 0xAA, 0xBB (LOAD_HOLD=1) -> two strobes with is_instruction=1: (addr 3, 0xAA), then (addr 4, 0xBB), each load high 1 cycle. Ends in HDR, cpu_reset stays 1.
- Stream 0x5F, 0x02, 0x11, 0x22 -> strobes at data address 31 (0x11) and 0 (0x22), showing wrap; then RUN with cpu_reset=0 one cycle after the second strobe ends.
- Send header 0x00 then length 0x28 -> err=1, no strobe. Next stream 0x40, 0x00 -> immediate RUN, cpu_reset=0.
- LOAD_HOLD=3, send one data byte 0x5A with in_valid held high -> load high 3 consecutive cycles, in_ready low for those cycles, next byte accepted 4 cycles after the first.
- In RUN, send header 0x81 -> cpu_reset=1 the following cycle and busy=1.
- Assert reset during STROBE -> load drops to 0 asynchronously, all outputs at reset values, FSM in HDR after release.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU program loader: FSM states, frame field
// positions and default widths.
package cpu_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 8;

    // Header byte layout: instr flag, GO flag, start address in the low bits
    localparam int HDR_INSTR_BIT = 7;
    localparam int HDR_GO_BIT    = 6;
    localparam int HDR_ADDR_MSB  = 4;

    // Length byte carries N in bits 5:0; anything above MAX_LEN is malformed
    localparam int LEN_MSB = 5;
    localparam int LEN_W   = LEN_MSB + 1;
    localparam int MAX_LEN = 32;

    // Wide enough for LOAD_HOLD up to 15
    localparam int HOLD_W = 4;

    typedef enum logic [2:0] {
        ST_HDR,
        ST_LEN,
        ST_DATA,
        ST_STROBE,
        ST_RUN
    } state_t;

endpackage

// File: rtl/cpu_program_loader_if.sv
// Byte-stream handshake plus the CPU load port driven by the program loader.
// master = the loader, slave = the byte source / CPU side.
interface cpu_program_loader_if
    import cpu_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);

    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;

    logic [DATA_W-1:0] cpu_input;
    logic [ADDR_W-1:0] load_address;
    logic              load;
    logic              is_instruction;
    logic              cpu_reset;
    logic              busy;
    logic              err;

    modport master (
        input  in_data,
        input  in_valid,
        output in_ready,
        output cpu_input,
        output load_address,
        output load,
        output is_instruction,
        output cpu_reset,
        output busy,
        output err
    );

    modport slave (
        output in_data,
        output in_valid,
        input  in_ready,
        input  cpu_input,
        input  load_address,
        input  load,
        input  is_instruction,
        input  cpu_reset,
        input  busy,
        input  err
    );

endinterface

// File: rtl/cpu_program_loader_hold_counter.sv
// Down-counter timing the load strobe: loaded with LOAD_HOLD-1 when a byte is
// accepted, last is high during the final hold cycle.
module loader_hold_counter
    import cpu_pkg::*;
#(
    parameter int LOAD_HOLD = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic last
);

    logic [HOLD_W-1:0] cnt;

    // NOTE: state registers use non-blocking (<=) so every flop samples the
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= HOLD_W'(LOAD_HOLD - 1);
        end else if (cnt != '0) begin
            cnt <= cnt - HOLD_W'(1);
        end
    end

    assign last = (cnt == '0);

endmodule

// File: rtl/cpu_program_loader.sv
// Parses header/length/data frames from a byte stream and writes each data
// byte into consecutive CPU memory addresses while holding the CPU in reset.
module cpu_program_loader
    import cpu_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int LOAD_HOLD = 1
) (
    input logic                  clk,
    input logic                  reset,
    cpu_program_loader_if.master bus
);

    state_t           state;
    logic             go;
    logic [LEN_W-1:0] remaining;
    logic             xfer;
    logic [LEN_W-1:0] len_field;
    logic             hold_last;

    assign xfer      = bus.in_valid && bus.in_ready;
    assign len_field = bus.in_data[LEN_MSB:0];

    loader_hold_counter #(
        .LOAD_HOLD(LOAD_HOLD)
    ) u_hold (
        .clk  (clk),
        .reset(reset),
        .start((state == ST_DATA) && xfer),
        .last (hold_last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state              <= ST_HDR;
            go                 <= 1'b0;
            remaining          <= '0;
            bus.in_ready       <= 1'b0;
            bus.cpu_input      <= '0;
            bus.load_address   <= '0;
            bus.load           <= 1'b0;
            bus.is_instruction <= 1'b0;
            bus.cpu_reset      <= 1'b1;
            bus.busy           <= 1'b0;
            bus.err            <= 1'b0;
        end else begin
            case (state)
                // A byte arriving while the CPU runs is a fresh header, so
                // reloading never needs an external reset.
                ST_HDR, ST_RUN: begin
                    bus.in_ready <= 1'b1;
                    if (xfer) begin
                        bus.is_instruction <= bus.in_data[HDR_INSTR_BIT];
                        go                 <= bus.in_data[HDR_GO_BIT];
                        bus.load_address   <= ADDR_W'(bus.in_data[HDR_ADDR_MSB:0]);
                        bus.cpu_reset      <= 1'b1;
                        bus.busy           <= 1'b1;
                        state              <= ST_LEN;
                    end else if (state == ST_RUN) begin
                        bus.cpu_reset <= 1'b0;
                    end
                end

                ST_LEN: begin
                    if (xfer) begin
                        if (len_field == '0) begin
                            bus.busy <= 1'b0;
                            state    <= go ? ST_RUN : ST_HDR;
                        end else if (len_field > LEN_W'(MAX_LEN)) begin
                            bus.err  <= 1'b1;
                            bus.busy <= 1'b0;
                            state    <= ST_HDR;
                        end else begin
                            remaining <= len_field;
                            state     <= ST_DATA;
                        end
                    end
                end

                ST_DATA: begin
                    if (xfer) begin
                        bus.cpu_input <= bus.in_data;
                        bus.load      <= 1'b1;
                        bus.in_ready  <= 1'b0;
                        state         <= ST_STROBE;
                    end
                end

                // Address and data stay frozen until the strobe's final cycle
                ST_STROBE: begin
                    if (hold_last) begin
                        bus.load         <= 1'b0;
                        bus.load_address <= bus.load_address + ADDR_W'(1);
                        remaining        <= remaining - LEN_W'(1);
                        bus.in_ready     <= 1'b1;
                        if (remaining == LEN_W'(1)) begin
                            bus.busy <= 1'b0;
                            state    <= go ? ST_RUN : ST_HDR;
                        end else begin
                            state <= ST_DATA;
                        end
                    end
                end

                default: state <= ST_HDR;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_program_loader.sv
// Self-checking bench: two loaders (LOAD_HOLD 1 and 3) driven with directed and
// random frames, checked against a frame-level model of expected memory writes.
module tb_cpu_program_loader;
    import cpu_pkg::*;

    localparam int HOLD_A = 1;
    localparam int HOLD_B = 3;

    typedef struct packed {
        logic       instr;
        logic [4:0] addr;
        logic [7:0] data;
    } wr_t;
    typedef logic [7:0] bq_t[$];

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    cpu_program_loader_if #(.ADDR_W(5), .DATA_W(8)) bus_a ();
    cpu_program_loader_if #(.ADDR_W(5), .DATA_W(8)) bus_b ();

    cpu_program_loader #(.ADDR_W(5), .DATA_W(8), .LOAD_HOLD(HOLD_A)) dut_a (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_a)
    );

    cpu_program_loader #(.ADDR_W(5), .DATA_W(8), .LOAD_HOLD(HOLD_B)) dut_b (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Strobe monitors: record each write at its first load cycle, its length,
    // and whether address/data moved while load was high.
    wr_t  cap_a[$], cap_b[$];
    int   len_a[$], len_b[$];
    int   run_a = 0, run_b = 0;
    int   unstable_a = 0, unstable_b = 0;
    logic prev_a = 1'b0, prev_b = 1'b0;
    wr_t  held_a, held_b;

    always @(negedge clk) begin
        if (reset) begin
            prev_a = 1'b0;
            run_a  = 0;
        end else begin
            if (bus_a.load) begin
                if (!prev_a) begin
                    held_a = {bus_a.is_instruction, bus_a.load_address, bus_a.cpu_input};
                    cap_a.push_back(held_a);
                    run_a = 1;
                end else begin
                    if (held_a != {bus_a.is_instruction, bus_a.load_address, bus_a.cpu_input})
                        unstable_a++;
                    run_a++;
                end
            end else if (prev_a) begin
                len_a.push_back(run_a);
            end
            prev_a = bus_a.load;
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            prev_b = 1'b0;
            run_b  = 0;
        end else begin
            if (bus_b.load) begin
                if (!prev_b) begin
                    held_b = {bus_b.is_instruction, bus_b.load_address, bus_b.cpu_input};
                    cap_b.push_back(held_b);
                    run_b = 1;
                end else begin
                    if (held_b != {bus_b.is_instruction, bus_b.load_address, bus_b.cpu_input})
                        unstable_b++;
                    run_b++;
                end
            end else if (prev_b) begin
                len_b.push_back(run_b);
            end
            prev_b = bus_b.load;
        end
    end

    // Reference model: walks a byte stream frame by frame and lists the writes
    // the CPU should see, plus where the loader should end up.
    wr_t  exp_a[$], exp_b[$];
    logic exp_err_a = 1'b0;
    logic exp_run_a = 1'b0;

    task automatic model(input bq_t s, input bit to_b);
        int         i;
        int         n;
        logic [7:0] h;
        wr_t        w;
        i = 0;
        while (i + 1 < s.size()) begin
            h = s[i];
            n = int'(s[i+1][5:0]);
            i += 2;
            if (n > 32) begin
                if (!to_b) begin
                    exp_err_a = 1'b1;
                    exp_run_a = 1'b0;
                end
                continue;
            end
            for (int k = 0; k < n; k++) begin
                w.instr = h[7];
                w.addr  = 5'((int'(h[4:0]) + k) % 32);
                w.data  = s[i];
                i++;
                if (to_b) exp_b.push_back(w);
                else      exp_a.push_back(w);
            end
            if (!to_b) exp_run_a = h[6];
        end
    endtask

    task automatic send_a(input logic [7:0] b);
        int waited;
        waited = 0;
        @(negedge clk);
        bus_a.in_data  = b;
        bus_a.in_valid = 1'b1;
        while (bus_a.in_ready !== 1'b1 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check("a_accept", bus_a.in_ready, 1'b1);
        @(posedge clk);
    endtask

    task automatic send_b(input logic [7:0] b);
        int waited;
        waited = 0;
        @(negedge clk);
        bus_b.in_data  = b;
        bus_b.in_valid = 1'b1;
        while (bus_b.in_ready !== 1'b1 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check("b_accept", bus_b.in_ready, 1'b1);
        @(posedge clk);
    endtask

    task automatic stream_a(input bq_t s);
        model(s, 1'b0);
        foreach (s[j]) send_a(s[j]);
    endtask

    task automatic stream_b(input bq_t s);
        model(s, 1'b1);
        foreach (s[j]) send_b(s[j]);
    endtask

    task automatic compare_a(input string tag);
        @(negedge clk);
        bus_a.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check({tag, "_count"}, cap_a.size(), exp_a.size());
        while (cap_a.size() > 0 && exp_a.size() > 0)
            check({tag, "_write"}, cap_a.pop_front(), exp_a.pop_front());
        cap_a.delete();
        exp_a.delete();
        foreach (len_a[j]) check({tag, "_hold"}, len_a[j], HOLD_A);
        len_a.delete();
        check({tag, "_unstable"}, unstable_a, 0);
        check({tag, "_cpu_reset"}, bus_a.cpu_reset, !exp_run_a);
        check({tag, "_busy"}, bus_a.busy, 1'b0);
        check({tag, "_err"}, bus_a.err, exp_err_a);
    endtask

    task automatic compare_b(input string tag);
        @(negedge clk);
        bus_b.in_valid = 1'b0;
        repeat (8) @(negedge clk);
        check({tag, "_count"}, cap_b.size(), exp_b.size());
        while (cap_b.size() > 0 && exp_b.size() > 0)
            check({tag, "_write"}, cap_b.pop_front(), exp_b.pop_front());
        cap_b.delete();
        exp_b.delete();
        foreach (len_b[j]) check({tag, "_hold"}, len_b[j], HOLD_B);
        len_b.delete();
        check({tag, "_unstable"}, unstable_b, 0);
        check({tag, "_busy"}, bus_b.busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    bq_t  s;
    int   acc[4];
    int   idx;
    int   ready_in_load;
    logic ready_now;

    initial begin
        bus_a.in_data  = '0;
        bus_a.in_valid = 1'b0;
        bus_b.in_data  = '0;
        bus_b.in_valid = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_cpu_reset", bus_a.cpu_reset, 1'b1);
        check("rst_load", bus_a.load, 1'b0);
        check("rst_addr", bus_a.load_address, 5'd0);
        check("rst_cpu_input", bus_a.cpu_input, 8'd0);
        check("rst_instr", bus_a.is_instruction, 1'b0);
        check("rst_ready", bus_a.in_ready, 1'b0);
        check("rst_busy", bus_a.busy, 1'b0);
        check("rst_err", bus_a.err, 1'b0);
        check("rst_b_cpu_reset", bus_b.cpu_reset, 1'b1);
        reset = 1'b0;

        // Two instruction bytes at addresses 3 and 4, no GO
        s = {8'h83, 8'h02, 8'hAA, 8'hBB};
        stream_a(s);
        compare_a("t1");

        // Data frame wrapping 31 -> 0, then RUN
        s = {8'h5F, 8'h02, 8'h11, 8'h22};
        stream_a(s);
        @(negedge clk);
        bus_a.in_valid = 1'b0;
        check("t2_load_hi", bus_a.load, 1'b1);
        @(negedge clk);
        check("t2_load_end", bus_a.load, 1'b0);
        check("t2_cpu_reset_held", bus_a.cpu_reset, 1'b1);
        @(negedge clk);
        check("t2_cpu_reset_rel", bus_a.cpu_reset, 1'b0);
        compare_a("t2");

        // Bad length sets sticky err, then an empty GO frame runs at once
        s = {8'h00, 8'h28};
        stream_a(s);
        compare_a("t3_err");
        s = {8'h40, 8'h00};
        stream_a(s);
        compare_a("t3_run");

        // New header while running puts the CPU back in reset
        s = {8'h81, 8'h00};
        model(s, 1'b0);
        send_a(8'h81);
        @(negedge clk);
        bus_a.in_valid = 1'b0;
        check("t5_cpu_reset", bus_a.cpu_reset, 1'b1);
        check("t5_busy", bus_a.busy, 1'b1);
        send_a(8'h00);
        compare_a("t5");

        // Random frames, including wraps, GO and occasional bad lengths
        for (int f = 0; f < 6; f++) begin
            int n;
            s = {};
            n = $urandom_range(0, 35);
            s.push_back(8'($urandom));
            s.push_back({2'($urandom), 6'(n)});
            if (n <= 32) for (int k = 0; k < n; k++) s.push_back(8'($urandom));
            stream_a(s);
        end
        compare_a("rand");

        // LOAD_HOLD=3 with in_valid held high throughout
        s = {8'h01, 8'h02, 8'h5A, 8'h6B};
        model(s, 1'b1);
        idx = 0;
        ready_in_load = 0;
        @(negedge clk);
        bus_b.in_data  = s[0];
        bus_b.in_valid = 1'b1;
        for (int c = 0; c < 60 && idx < 4; c++) begin
            ready_now = bus_b.in_ready;
            if (bus_b.load && bus_b.in_ready) ready_in_load++;
            @(posedge clk);
            if (ready_now) begin
                acc[idx] = c;
                idx++;
            end
            @(negedge clk);
            if (idx < 4) bus_b.in_data = s[idx];
            else         bus_b.in_valid = 1'b0;
        end
        check("b_all_accepted", idx, 4);
        check("b_data_gap", acc[3] - acc[2], HOLD_B + 1);
        check("b_len_to_data", acc[2] - acc[1], 1);
        check("b_ready_in_load", ready_in_load, 0);
        compare_b("t4");

        // Reset during a strobe aborts it immediately
        send_b(8'h80);
        send_b(8'h01);
        send_b(8'h77);
        #1;
        check("t6_pre_load", bus_b.load, 1'b1);
        #1;
        reset = 1'b1;
        bus_b.in_valid = 1'b0;
        #1;
        check("t6_load", bus_b.load, 1'b0);
        check("t6_cpu_reset", bus_b.cpu_reset, 1'b1);
        check("t6_ready", bus_b.in_ready, 1'b0);
        check("t6_busy", bus_b.busy, 1'b0);
        check("t6_addr", bus_b.load_address, 5'd0);
        check("t6_cpu_input", bus_b.cpu_input, 8'd0);
        check("t6_instr", bus_b.is_instruction, 1'b0);
        @(negedge clk);
        @(posedge clk);
        #2;
        reset = 1'b0;
        s = {8'h82, 8'h01, 8'h33};
        stream_b(s);
        compare_b("t6");

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
